// File: rtl/sec_mask_pkg.sv
// rtl/sec_mask_pkg.sv - shared definitions for the masked conversion gadgets
//
// Purpose: default share geometry, the ISW random-bit count, the lexicographic
//          pair index used to pick r_pq out of a flat random vector, and the
//          FSM state type of the serial A2B converter.
// Ports:   none (package).

package sec_mask_pkg;

  localparam int K_WIDTH_DEF  = 32;
  localparam int N_SHARES_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fresh random bits needed by one N-share ISW AND.
  function automatic int rand_and(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Position of pair (p,q), p<q, when pairs are enumerated
  // (0,1),(0,2)...(0,n-1),(1,2)...(n-2,n-1).
  function automatic int idx(input int p, input int q, input int n);
    return p * (2 * n - p - 1) / 2 + (q - p - 1);
  endfunction

endpackage

// File: rtl/sec_and_n.sv
// rtl/sec_and_n.sv - combinational N-share ISW SecAnd over 1-bit shares
//
// Purpose: z = x & y on Boolean-shared single bits, ISW construction.
// Ports:
//   x, y  in   N     input sharings (share s = bit s)
//   r     in   RW    fresh randomness, r_pq = r[idx(p,q,N)]
//   z     out  N     output sharing of x & y

module sec_and_n
  import sec_mask_pkg::*;
#(
  parameter int N  = N_SHARES_DEF,
  parameter int RW = (rand_and(N) > 0) ? rand_and(N) : 1
) (
  input  logic [N-1:0]  x,
  input  logic [N-1:0]  y,
  input  logic [RW-1:0] r,
  output logic [N-1:0]  z
);

  // t[p][q] is the cross-term contribution share p receives from pair {p,q}.
  // The lower share of a pair takes r_pq directly; the upper share takes
  // (r_pq ^ x_p y_q) ^ x_q y_p, bracketed in that order so r masks first.
  logic [N-1:0] t [N];

  for (genvar p = 0; p < N; p++) begin : g_row
    for (genvar q = 0; q < N; q++) begin : g_col
      if (p < q) begin : g_lo
        assign t[p][q] = r[idx(p, q, N)];
      end else if (p > q) begin : g_hi
        assign t[p][q] = (r[idx(q, p, N)] ^ (x[q] & y[p])) ^ (x[p] & y[q]);
      end else begin : g_diag
        assign t[p][q] = 1'b0;
      end
    end
    assign z[p] = (x[p] & y[p]) ^ (^t[p]);
  end

endmodule

// File: rtl/sec_a2b_serial.sv
// rtl/sec_a2b_serial.sv - bit-serial arithmetic-to-Boolean mask converter
//
// Purpose: converts an N-share arithmetic sharing (sum mod 2^K) into an
//          N-share Boolean sharing by adding shares 1..N-1 into a Boolean
//          accumulator z one bit per cycle with a masked ripple carry.
// Ports:
//   clk, rst_n  in   1          clock, asynchronous active-low reset
//   i_vld       in   1          input sharing valid
//   o_rdy       out  1          idle; input accepted on i_vld && o_rdy
//   i_a         in   MASKWIDTH  arithmetic shares, share s at [s*K +: K]
//   rnd         in   RAND_AND   fresh randomness for this cycle
//   rnd_vld     in   1          rnd valid; low freezes the ADD phase
//   o_b         out  MASKWIDTH  Boolean shares, same packing as i_a
//   ovld        out  1          one-cycle pulse, o_b valid

module sec_a2b_serial
  import sec_mask_pkg::*;
#(
  parameter int K_WIDTH   = K_WIDTH_DEF,
  parameter int N_SHARES  = N_SHARES_DEF,
  parameter int MASKWIDTH = K_WIDTH * N_SHARES,
  parameter int RAND_AND  = rand_and(N_SHARES)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_vld,
  output logic                                  o_rdy,
  input  logic [MASKWIDTH-1:0]                  i_a,
  input  logic [((RAND_AND > 0) ? RAND_AND : 1)-1:0] rnd,
  input  logic                                  rnd_vld,
  output logic [MASKWIDTH-1:0]                  o_b,
  output logic                                  ovld
);

  localparam int RW = (RAND_AND > 0) ? RAND_AND : 1;
  // Shares 1..N-1 are kept; share s lives at a_q[(s-1)*K +: K].
  localparam int AW = (N_SHARES > 1) ? (N_SHARES - 1) * K_WIDTH : K_WIDTH;
  localparam int IW = (N_SHARES > 1) ? $clog2(N_SHARES) : 1;
  localparam int JW = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_SHARES - 1);
  localparam logic [JW-1:0] J_LAST = JW'(K_WIDTH - 1);

  state_t                state_q, state_d;
  logic [MASKWIDTH-1:0]  z_q, z_d;
  logic [AW-1:0]         a_q;
  logic [N_SHARES-1:0]   c_q;
  logic [IW-1:0]         i_q;
  logic [JW-1:0]         j_q;

  logic                  accept, add_step, wrap, last_step;
  logic [K_WIDTH-1:0]    a_cur, xs, zs;
  logic [N_SHARES-1:0]   x_bit, y_bit, s_bit, and_out, c_next;

  assign o_rdy     = (state_q == IDLE);
  assign accept    = (state_q == IDLE) && i_vld;
  assign add_step  = (state_q == ADD) && rnd_vld;
  assign wrap      = (j_q == J_LAST);
  assign last_step = add_step && wrap && (i_q == I_LAST);

  // Operand bits for the current (i, j): x from the accumulator, y is the
  // trivially shared bit j of a_i (only share 0 non-zero).
  always_comb begin
    a_cur = '0;
    x_bit = '0;
    y_bit = '0;
    xs    = '0;
    for (int s = 1; s < N_SHARES; s++) begin
      if (i_q == IW'(s)) a_cur = a_q[(s-1)*K_WIDTH +: K_WIDTH];
    end
    for (int s = 0; s < N_SHARES; s++) begin
      xs       = z_q[s*K_WIDTH +: K_WIDTH];
      x_bit[s] = xs[j_q];
    end
    y_bit[0] = a_cur[j_q];
  end

  assign s_bit = x_bit ^ y_bit ^ c_q;

  // Masked majority: maj(x,y,c) = ((x^c) & (y^c)) ^ c.
  sec_and_n #(
    .N  (N_SHARES),
    .RW (RW)
  ) u_and (
    .x (x_bit ^ c_q),
    .y (y_bit ^ c_q),
    .r (rnd),
    .z (and_out)
  );

  assign c_next = and_out ^ c_q;

  always_comb begin
    z_d = z_q;
    zs  = '0;
    if (accept) begin
      z_d = MASKWIDTH'(i_a[K_WIDTH-1:0]);
    end else if (add_step) begin
      for (int s = 0; s < N_SHARES; s++) begin
        zs                        = z_q[s*K_WIDTH +: K_WIDTH];
        zs[j_q]                   = s_bit[s];
        z_d[s*K_WIDTH +: K_WIDTH] = zs;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_vld) state_d = (N_SHARES == 1) ? DONE : ADD;
      ADD:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      z_q     <= '0;
      a_q     <= '0;
      c_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      o_b     <= '0;
      ovld    <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      ovld    <= (state_q == DONE);
      if (state_q == DONE) o_b <= z_q;
      if (accept) begin
        a_q <= i_a[MASKWIDTH-1 -: AW];
        i_q <= IW'(1);
        j_q <= '0;
        c_q <= '0;
      end else if (add_step) begin
        if (wrap) begin
          // Carry out of the top bit is dropped: addition is mod 2^K.
          j_q <= '0;
          i_q <= i_q + IW'(1);
          c_q <= '0;
        end else begin
          j_q <= j_q + JW'(1);
          c_q <= c_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_sec_a2b_serial.sv
// tb/tb_sec_a2b_serial.sv - randomized self-checking bench for sec_a2b_serial

module tb_sec_a2b_serial;

  localparam int K  = 32;
  localparam int N  = 8;
  localparam int MW = K * N;
  localparam int RA = N * (N - 1) / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_vld, rnd_vld, o_rdy, ovld;
  logic [MW-1:0] i_a, o_b;
  logic [RA-1:0] rnd;

  logic          v1, rnd1, rv1, rdy1, ov1;
  logic [31:0]   a1, b1;
  logic          v2, rnd2, rv2, rdy2, ov2;
  logic [63:0]   a2, b2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sec_a2b_serial u_dut (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .o_rdy(o_rdy), .i_a(i_a),
    .rnd(rnd), .rnd_vld(rnd_vld), .o_b(o_b), .ovld(ovld)
  );

  sec_a2b_serial #(.K_WIDTH(32), .N_SHARES(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .i_vld(v1), .o_rdy(rdy1), .i_a(a1),
    .rnd(rnd1), .rnd_vld(rv1), .o_b(b1), .ovld(ov1)
  );

  sec_a2b_serial #(.K_WIDTH(32), .N_SHARES(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .i_vld(v2), .o_rdy(rdy2), .i_a(a2),
    .rnd(rnd2), .rnd_vld(rv2), .o_b(b2), .ovld(ov2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: the arithmetic value is the plain sum of shares mod 2^32,
  // the Boolean value is the XOR of shares.
  function automatic logic [31:0] share_sum(input logic [MW-1:0] a, input int n);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < n; k++) s = s + a[k*K +: K];
    return s;
  endfunction

  function automatic logic [31:0] share_xor(input logic [MW-1:0] b, input int n);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < n; k++) s = s ^ b[k*K +: K];
    return s;
  endfunction

  function automatic logic [MW-1:0] make_shares(input logic [31:0] v, input int n);
    logic [MW-1:0] a;
    logic [31:0]   rest;
    a    = '0;
    rest = '0;
    for (int k = 1; k < n; k++) begin
      a[k*K +: K] = $urandom;
      rest        = rest + a[k*K +: K];
    end
    a[K-1:0] = v - rest;
    return a;
  endfunction

  // Runs one conversion on the N=8 instance. Starts and ends #1 after a
  // rising edge. lat counts rising edges after the accepting edge until
  // ovld is seen; -1 if the cycle budget ran out.
  task automatic convert(input logic [MW-1:0] a, input int stalls, input bit zero_rnd,
                         input bit pulse, output logic [31:0] res, output int lat,
                         output bit rdy_bad, output bit tail_bad);
    int n;
    i_vld = 1'b1;
    i_a   = a;
    rnd   = RA'($urandom);
    rnd_vld = 1'b1;
    check("rdy_before_accept", o_rdy, 1'b1);
    @(posedge clk); #1;
    i_vld   = 1'b0;
    i_a     = {8{$urandom}};
    lat     = -1;
    rdy_bad = 1'b0;
    n       = 0;
    while (n < 400 && lat < 0) begin
      if (ovld) begin
        lat = n;
      end else begin
        if (o_rdy) rdy_bad = 1'b1;
        rnd     = zero_rnd ? '0 : RA'($urandom);
        rnd_vld = !((n % 20 == 10) && (n / 20 < stalls));
        i_vld   = pulse && (n == 5 || n == 100);
        if (i_vld) i_a = {8{$urandom}};
        @(posedge clk); #1;
        n++;
      end
    end
    i_vld = 1'b0;
    res   = share_xor(o_b, N);
    check("rdy_with_ovld", o_rdy, 1'b1);
    @(posedge clk); #1;
    tail_bad = ovld || !o_rdy;
  endtask

  task automatic conv_small(input bit two, input logic [63:0] a,
                            output logic [31:0] res, output int lat);
    int n;
    if (two) begin v2 = 1'b1; a2 = a; end
    else     begin v1 = 1'b1; a1 = a[31:0]; end
    rv1 = 1'b1;
    rv2 = 1'b1;
    @(posedge clk); #1;
    v1  = 1'b0;
    v2  = 1'b0;
    lat = -1;
    n   = 0;
    while (n < 200 && lat < 0) begin
      if (two ? ov2 : ov1) begin
        lat = n;
      end else begin
        rnd1 = 1'($urandom);
        rnd2 = 1'($urandom);
        @(posedge clk); #1;
        n++;
      end
    end
    res = two ? (b2[31:0] ^ b2[63:32]) : b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [MW-1:0] a;
    logic [31:0]   res, v;
    int            lat, st, seen;
    bit            rb, tb, zr;

    i_vld = 1'b0; i_a = '0; rnd = '0; rnd_vld = 1'b0;
    v1 = 1'b0; a1 = '0; rnd1 = 1'b0; rv1 = 1'b0;
    v2 = 1'b0; a2 = '0; rnd2 = 1'b0; rv2 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("in_reset_ovld", ovld, 1'b0);
    check("in_reset_rdy", o_rdy, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_ovld", ovld, 1'b0);
    check("reset_rdy", o_rdy, 1'b1);
    check("reset_ob_zero", o_b == '0, 1'b1);
    check("reset_n1_rdy", rdy1, 1'b1);
    check("reset_n2_rdy", rdy2, 1'b1);
    check("reset_small_ob_zero", (b1 == '0) && (b2 == '0), 1'b1);

    // Directed value with random masks.
    a = make_shares(32'h1234_5678, N);
    convert(a, 0, 1'b0, 1'b0, res, lat, rb, tb);
    check("basic_result", res, 32'h1234_5678);
    check("basic_latency", lat, 225);
    check("basic_rdy_low", rb, 1'b0);
    check("basic_single_pulse", tb, 1'b0);

    // All-ones shares: 8 * 0xFFFFFFFF mod 2^32.
    a = {N{32'hFFFF_FFFF}};
    convert(a, 0, 1'b0, 1'b0, res, lat, rb, tb);
    check("allones_result", res, 32'hFFFF_FFF8);
    check("allones_latency", lat, 225);

    // Ten isolated stalls and all-zero randomness.
    a = make_shares(32'h1234_5678, N);
    convert(a, 10, 1'b1, 1'b0, res, lat, rb, tb);
    check("stall_result", res, 32'h1234_5678);
    check("stall_latency", lat, 235);
    check("stall_rdy_low", rb, 1'b0);

    // i_vld pulses during ADD must be ignored.
    a = make_shares(32'hCAFE_0001, N);
    convert(a, 0, 1'b0, 1'b1, res, lat, rb, tb);
    check("ivld_ignored_result", res, 32'hCAFE_0001);
    check("ivld_ignored_latency", lat, 225);
    check("ivld_ignored_rdy_low", rb, 1'b0);
    check("ivld_ignored_single", tb, 1'b0);

    // Reset in the middle of a conversion.
    a = make_shares(32'hDEAD_BEEF, N);
    i_vld = 1'b1; i_a = a; rnd_vld = 1'b1;
    @(posedge clk); #1;
    i_vld = 1'b0;
    repeat (100) begin rnd = RA'($urandom); @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort_ob_zero", o_b == '0, 1'b1);
    check("abort_ovld", ovld, 1'b0);
    check("abort_rdy", o_rdy, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (300) begin
      if (ovld) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_ovld", seen, 0);
    check("abort_rdy_after", o_rdy, 1'b1);
    check("abort_ob_after", o_b == '0, 1'b1);
    a = make_shares(32'h0BAD_F00D, N);
    convert(a, 0, 1'b0, 1'b0, res, lat, rb, tb);
    check("post_abort_result", res, 32'h0BAD_F00D);
    check("post_abort_latency", lat, 225);

    // Random regression on the N=8 instance.
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < N; k++) a[k*K +: K] = $urandom;
      st = $urandom_range(0, 5);
      zr = ($urandom_range(0, 7) == 0);
      convert(a, st, zr, 1'b0, res, lat, rb, tb);
      check("rand8_result", res, share_sum(a, N));
      check("rand8_latency", lat, 225 + st);
    end

    // Degenerate and minimal share counts.
    conv_small(1'b0, 64'h0000_0000_8000_0001, res, lat);
    check("n1_roundtrip", res, 32'h8000_0001);
    check("n1_latency", lat, 1);
    a = make_shares(32'h8000_0001, 2);
    conv_small(1'b1, a[63:0], res, lat);
    check("n2_roundtrip", res, 32'h8000_0001);
    check("n2_latency", lat, 33);

    for (int t = 0; t < 1000; t++) begin
      v = $urandom;
      conv_small(1'b0, {32'h0, v}, res, lat);
      check("rand1_result", res, v);
    end
    for (int t = 0; t < 400; t++) begin
      a = '0;
      a[63:0] = {$urandom, $urandom};
      conv_small(1'b1, a[63:0], res, lat);
      check("rand2_result", res, share_sum(a, 2));
      check("rand2_latency", lat, 33);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
